food_tile_drawer: RTL and testbench
===================================

Name: food_tile_drawer

Overview:
Initiator side of the food sprite lookup. On a start request it sweeps one 16x16 maze tile pixel by pixel and drives x/y/type to a food_layout responder. It takes the 2-bit pixel value that comes back, maps it through a 3-colour palette and pushes coloured pixels to the framebuffer writer over a valid/ready handshake. It sits between the maze game logic (which requests redraws of eaten or spawned food) and the framebuffer.

Parameters:
GRID_W_BITS, 5, tile column index width; fb_x width = GRID_W_BITS+4
GRID_H_BITS, 5, tile row index width; fb_y width = GRID_H_BITS+4
COLOR_W, 12, framebuffer colour width
COLOR1, 12'hFA0, colour for layout value 1
COLOR2, 12'hF00, colour for layout value 2
COLOR3, 12'hFFF, colour for layout value 3
BG_COLOR, 12'h000, background colour (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  draw request, sampled only in IDLE
tile_col  in  GRID_W_BITS  tile column, latched on start
tile_row  in  GRID_H_BITS  tile row, latched on start
food_type  in  2  food type, latched on start
busy  out  1  high from the cycle after start acceptance until DONE completes
done  out  1  one-cycle pulse when the tile is finished
lay_x  out  4  pixel x within tile, to layout
lay_y  out  4  pixel y within tile, to layout
lay_type  out  2  latched food type, to layout
lay_value  in  2  combinational pixel value from layout for current lay_x/lay_y/lay_type
fb_valid  out  1  pixel write request
fb_ready  in  1  framebuffer accepts the write
fb_x  out  GRID_W_BITS+4  screen x = {tile_col, px}
fb_y  out  GRID_H_BITS+4  screen y = {tile_row, py}
fb_color  out  COLOR_W  pixel colour

Behaviour:
- Reset, on the rising edge of clk with rst=1: state IDLE; busy=0, done=0, fb_valid=0; fb_x, fb_y, fb_color, lay_x, lay_y, lay_type all 0. rst takes priority over every other input, including mid-sweep and mid-handshake. fb_valid drops on that edge even if fb_ready was low.
- States: IDLE, FETCH, WRITE, DONE.
- IDLE: if start=1, latch tile_col/tile_row/food_type, clear px/py to 0 and go to FETCH. Otherwise stay in IDLE.
- Outputs are always driven as lay_x=px, lay_y=py, lay_type=latched type.
- FETCH (1 cycle per pixel): sample lay_value in the same cycle.
  - If lay_value != 0: load fb_x={col,px}, fb_y={row,py} and fb_color=palette(lay_value), then go to WRITE.
  - If lay_value == 0: skip the pixel. On the last pixel go to DONE; otherwise advance and stay in FETCH.
- WRITE: fb_valid=1. fb_x, fb_y and fb_color hold stable until fb_valid&&fb_ready. On that handshake, go to DONE if it was the last pixel, else advance and go to FETCH. fb_valid never deasserts without a handshake, except on reset.
- Advance order: px increments 0..15; when px wraps 15->0, py increments. Last pixel is px=15, py=15. No pixel is visited twice or skipped by the counters.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in FETCH, WRITE and DONE.
- start is ignored while not in IDLE, and the latched inputs do not change during a sweep.
- Timing with fb_ready tied high and start accepted at edge 0: done is asserted in cycle 257+N, where N is the number of pixels written. Start can be re-accepted in the cycle after done.
- Palette: 1->COLOR1, 2->COLOR2, 3->COLOR3. Outputs are truncated/zero-extended to COLOR_W.

Optional Feature:
FOOD_DRAW_CLEAR_EN
- Defined: value-0 pixels are not skipped. They go to WRITE with fb_color=BG_COLOR, so all 256 tile pixels are written, erasing the old food. Cycle count to done with fb_ready high is 513.
- Undefined: value-0 pixels are transparent and produce no framebuffer write.

Test Plan:
The bench instantiates food_layout as the responder on the lay_* ports.
- Type 0, tile (1,1), fb_ready=1, no macro -> zero fb_valid pulses; done in cycle 257 after start; busy high for cycles 1..257.
- Type 1, tile (2,3), fb_ready=1 -> exactly 12 writes. First write is fb_x=39, fb_y=54, fb_color=COLOR2, second is fb_x=40, fb_y=54, COLOR2; done in cycle 269.
- Type 2, tile (0,0), fb_ready random 50% -> exactly 17 writes in raster order. fb_x/fb_y/fb_color stay stable while fb_valid=1 and fb_ready=0; done exactly once.
- Type 1 sweep, start pulsed again during FETCH/WRITE with tile (9,9) -> ignored; all writes stay within x 32..47, y 48..63.
- rst asserted while in WRITE with fb_ready=0 -> fb_valid=0 and busy=0 after the edge, no done pulse. A following start gives a full normal sweep.
- FOOD_DRAW_CLEAR_EN, type 1, tile (0,0) -> 256 writes, 244 with BG_COLOR; first write is (0,0,BG_COLOR); done in cycle 513.

Source files
------------

// File: rtl/food_tile_drawer.sv
// Sweeps one 16x16 food tile through the layout responder and writes coloured pixels to the framebuffer.
// Optional macro FOOD_DRAW_CLEAR_EN: value-0 pixels are written as BG_COLOR instead of being skipped.
module food_tile_drawer #(
    parameter int          GRID_W_BITS = 5,
    parameter int          GRID_H_BITS = 5,
    parameter int          COLOR_W     = 12,
    parameter logic [11:0] COLOR1      = 12'hFA0,
    parameter logic [11:0] COLOR2      = 12'hF00,
    parameter logic [11:0] COLOR3      = 12'hFFF,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [GRID_W_BITS-1:0]   tile_col,
    input  logic [GRID_H_BITS-1:0]   tile_row,
    input  logic [1:0]               food_type,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               lay_x,
    output logic [3:0]               lay_y,
    output logic [1:0]               lay_type,
    input  logic [1:0]               lay_value,
    output logic                     fb_valid,
    input  logic                     fb_ready,
    output logic [GRID_W_BITS+3:0]   fb_x,
    output logic [GRID_H_BITS+3:0]   fb_y,
    output logic [COLOR_W-1:0]       fb_color
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [GRID_W_BITS-1:0]   col_q, col_d;
    logic [GRID_H_BITS-1:0]   row_q, row_d;
    logic [1:0]               type_q, type_d;
    logic [3:0]               px_q, px_d;
    logic [3:0]               py_q, py_d;
    logic [GRID_W_BITS+3:0]   fb_x_q, fb_x_d;
    logic [GRID_H_BITS+3:0]   fb_y_q, fb_y_d;
    logic [COLOR_W-1:0]       fb_color_q, fb_color_d;
    logic                     fb_valid_q, fb_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     last_pix;
    logic                     write_pix;

    function automatic logic [COLOR_W-1:0] palette(input logic [1:0] v);
        case (v)
            2'd1:    palette = COLOR_W'(COLOR1);
            2'd2:    palette = COLOR_W'(COLOR2);
            2'd3:    palette = COLOR_W'(COLOR3);
            default: palette = COLOR_W'(BG_COLOR);
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        type_d     = type_q;
        px_d       = px_q;
        py_d       = py_q;
        fb_x_d     = fb_x_q;
        fb_y_d     = fb_y_q;
        fb_color_d = fb_color_q;
        last_pix   = (px_q == 4'hF) && (py_q == 4'hF);
`ifdef FOOD_DRAW_CLEAR_EN
        write_pix  = 1'b1;
`else
        write_pix  = (lay_value != 2'd0);
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    col_d   = tile_col;
                    row_d   = tile_row;
                    type_d  = food_type;
                    px_d    = 4'd0;
                    py_d    = 4'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (write_pix) begin
                    fb_x_d     = {col_q, px_q};
                    fb_y_d     = {row_q, py_q};
                    fb_color_d = palette(lay_value);
                    state_d    = WRITE;
                end else if (last_pix) begin
                    state_d = DONE;
                end else begin
                    {py_d, px_d} = {py_q, px_q} + 8'd1;
                end
            end
            WRITE: begin
                // Coordinates and colour stay frozen until the framebuffer takes the pixel.
                if (fb_ready) begin
                    if (last_pix) begin
                        state_d = DONE;
                    end else begin
                        {py_d, px_d} = {py_q, px_q} + 8'd1;
                        state_d      = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        fb_valid_d = (state_d == WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            type_q     <= '0;
            px_q       <= '0;
            py_q       <= '0;
            fb_x_q     <= '0;
            fb_y_q     <= '0;
            fb_color_q <= '0;
            fb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            type_q     <= type_d;
            px_q       <= px_d;
            py_q       <= py_d;
            fb_x_q     <= fb_x_d;
            fb_y_q     <= fb_y_d;
            fb_color_q <= fb_color_d;
            fb_valid_q <= fb_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign fb_valid = fb_valid_q;
    assign fb_x     = fb_x_q;
    assign fb_y     = fb_y_q;
    assign fb_color = fb_color_q;
    assign lay_x    = px_q;
    assign lay_y    = py_q;
    assign lay_type = type_q;

endmodule

// File: tb/tb_food_tile_drawer.sv
// Directed bench for food_tile_drawer with a behavioural food_layout responder on the lay_* ports.
module tb_food_tile_drawer;

    localparam int          GW = 5;
    localparam int          GH = 5;
    localparam int          CW = 12;
    localparam logic [11:0] C1 = 12'hFA0;
    localparam logic [11:0] C2 = 12'hF00;
    localparam logic [11:0] C3 = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;
`ifdef FOOD_DRAW_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [GW-1:0]  tile_col;
    logic [GH-1:0]  tile_row;
    logic [1:0]     food_type;
    logic           busy;
    logic           done;
    logic [3:0]     lay_x;
    logic [3:0]     lay_y;
    logic [1:0]     lay_type;
    logic [1:0]     lay_value;
    logic           fb_valid;
    logic           fb_ready;
    logic [GW+3:0]  fb_x;
    logic [GH+3:0]  fb_y;
    logic [CW-1:0]  fb_color;

    int total = 0;
    int bad   = 0;

    int n_writes, done_cnt, done_cyc, stall_err, range_err, busy_err, bg_cnt;
    logic [8:0]  wx[$];
    logic [8:0]  wy[$];
    logic [11:0] wc[$];

    food_tile_drawer #(
        .GRID_W_BITS(GW), .GRID_H_BITS(GH), .COLOR_W(CW),
        .COLOR1(C1), .COLOR2(C2), .COLOR3(C3), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .tile_col(tile_col), .tile_row(tile_row), .food_type(food_type),
        .busy(busy), .done(done),
        .lay_x(lay_x), .lay_y(lay_y), .lay_type(lay_type), .lay_value(lay_value),
        .fb_valid(fb_valid), .fb_ready(fb_ready),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color)
    );

    always #5 clk = ~clk;

    // Type 0 is empty, type 1 has 12 lit pixels, type 2 has 17.
    function automatic logic [1:0] layout(input logic [1:0] t, input logic [3:0] x, input logic [3:0] y);
        layout = 2'd0;
        if (t == 2'd1) begin
            if (y == 4'd6 && (x == 4'd7 || x == 4'd8))  layout = 2'd2;
            if (y == 4'd7 && x >= 4'd6 && x <= 4'd9)    layout = 2'd2;
            if (y == 4'd8 && x >= 4'd6 && x <= 4'd9)    layout = 2'd1;
            if (y == 4'd9 && (x == 4'd7 || x == 4'd8))  layout = 2'd3;
        end else if (t == 2'd2) begin
            if (y == 4'd5 && x >= 4'd5 && x <= 4'd11)   layout = 2'd1;
            if (y == 4'd6 && x >= 4'd5 && x <= 4'd14)   layout = 2'd3;
        end
    endfunction

    function automatic logic [11:0] pal(input logic [1:0] v);
        case (v)
            2'd1:    pal = C1;
            2'd2:    pal = C2;
            2'd3:    pal = C3;
            default: pal = BG;
        endcase
    endfunction

    assign lay_value = layout(lay_type, lay_x, lay_y);

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int order_errors(input logic [1:0] t, input logic [4:0] col, input logic [4:0] row);
        int idx = 0;
        int errs = 0;
        logic [1:0] v;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                v = layout(t, 4'(x), 4'(y));
                if (CLEAR || v != 2'd0) begin
                    if (idx >= wx.size()) errs++;
                    else if (wx[idx] !== {col, 4'(x)} || wy[idx] !== {row, 4'(y)} || wc[idx] !== pal(v)) errs++;
                    idx++;
                end
            end
        end
        if (idx != wx.size()) errs++;
        return errs;
    endfunction

    // One full sweep: start at edge 0, monitor every cycle until done (bounded), then a few idle cycles.
    task automatic applyStimulus(input logic [1:0] t, input logic [4:0] col, input logic [4:0] row,
                                 input bit rand_ready, input bit poke);
        int cyc;
        bit prev_stall;
        bit seen_done;
        logic [8:0]  p_x;
        logic [8:0]  p_y;
        logic [11:0] p_c;
        wx.delete(); wy.delete(); wc.delete();
        n_writes = 0; done_cnt = 0; done_cyc = -1; stall_err = 0;
        range_err = 0; busy_err = 0; bg_cnt = 0;
        p_x = '0; p_y = '0; p_c = '0;
        @(negedge clk);
        tile_col = col; tile_row = row; food_type = t; start = 1'b1; fb_ready = 1'b1;
        cyc = 0; prev_stall = 0; seen_done = 0;
        while (!seen_done && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (poke && (cyc % 5 == 0)) begin
                start = 1'b1; tile_col = 5'd9; tile_row = 5'd9; food_type = 2'd2;
            end
            if (busy !== 1'b1) busy_err++;
            if (prev_stall && (fb_valid !== 1'b1 || fb_x !== p_x || fb_y !== p_y || fb_color !== p_c))
                stall_err++;
            if (done === 1'b1) begin
                done_cnt++; done_cyc = cyc; seen_done = 1; start = 1'b0;
            end
            fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (fb_valid === 1'b1 && fb_ready) begin
                wx.push_back(fb_x); wy.push_back(fb_y); wc.push_back(fb_color);
                n_writes++;
                if (fb_x[8:4] !== col || fb_y[8:4] !== row) range_err++;
                if (fb_color === BG) bg_cnt++;
            end
            prev_stall = (fb_valid === 1'b1) && !fb_ready;
            p_x = fb_x; p_y = fb_y; p_c = fb_color;
        end
        start = 1'b0; fb_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (done !== 1'b0) done_cnt++;
            if (busy !== 1'b0 || fb_valid !== 1'b0) busy_err++;
        end
    endtask

    initial begin
        int wait_cnt;
        int late_done;
        rst = 1'b1; start = 1'b0; tile_col = '0; tile_row = '0; food_type = '0; fb_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_fb_valid", fb_valid, 0);
        checkOutput("rst_fb_x", fb_x, 0);
        checkOutput("rst_fb_y", fb_y, 0);
        checkOutput("rst_fb_color", fb_color, 0);
        checkOutput("rst_lay_x", lay_x, 0);
        checkOutput("rst_lay_y", lay_y, 0);
        checkOutput("rst_lay_type", lay_type, 0);
        rst = 1'b0;

        applyStimulus(2'd0, 5'd1, 5'd1, 1'b0, 1'b0);
        checkOutput("t0_writes", n_writes, CLEAR ? 256 : 0);
        checkOutput("t0_done_cyc", done_cyc, CLEAR ? 513 : 257);
        checkOutput("t0_done_cnt", done_cnt, 1);
        checkOutput("t0_busy", busy_err, 0);

        applyStimulus(2'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        checkOutput("t1_writes", n_writes, CLEAR ? 256 : 12);
        checkOutput("t1_done_cyc", done_cyc, CLEAR ? 513 : 269);
        checkOutput("t1_w0_x", wx.size() > 0 ? wx[0] : 9'h1FF, CLEAR ? 32 : 39);
        checkOutput("t1_w0_y", wy.size() > 0 ? wy[0] : 9'h1FF, CLEAR ? 48 : 54);
        checkOutput("t1_w0_c", wc.size() > 0 ? wc[0] : 12'hBAD, CLEAR ? BG : C2);
        checkOutput("t1_w1_x", wx.size() > 1 ? wx[1] : 9'h1FF, CLEAR ? 33 : 40);
        checkOutput("t1_w1_c", wc.size() > 1 ? wc[1] : 12'hBAD, CLEAR ? BG : C2);
        checkOutput("t1_order", order_errors(2'd1, 5'd2, 5'd3), 0);
        checkOutput("t1_busy", busy_err, 0);

        applyStimulus(2'd2, 5'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("t2_writes", n_writes, CLEAR ? 256 : 17);
        checkOutput("t2_done_cnt", done_cnt, 1);
        checkOutput("t2_stall_stable", stall_err, 0);
        checkOutput("t2_order", order_errors(2'd2, 5'd0, 5'd0), 0);
        checkOutput("t2_w0_x", wx.size() > 0 ? wx[0] : 9'h1FF, CLEAR ? 0 : 5);
        checkOutput("t2_w0_c", wc.size() > 0 ? wc[0] : 12'hBAD, CLEAR ? BG : C1);

        applyStimulus(2'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        checkOutput("t3_range", range_err, 0);
        checkOutput("t3_writes", n_writes, CLEAR ? 256 : 12);
        checkOutput("t3_done_cyc", done_cyc, CLEAR ? 513 : 269);
        checkOutput("t3_order", order_errors(2'd1, 5'd2, 5'd3), 0);

        // Reset while stalled in WRITE must abandon the sweep cleanly.
        @(negedge clk);
        tile_col = 5'd2; tile_row = 5'd3; food_type = 2'd1; start = 1'b1; fb_ready = 1'b0;
        wait_cnt = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            wait_cnt++;
        end while (fb_valid !== 1'b1 && wait_cnt < 400);
        checkOutput("rw_reached_write", fb_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rw_fb_valid", fb_valid, 0);
        checkOutput("rw_busy", busy, 0);
        checkOutput("rw_done", done, 0);
        checkOutput("rw_lay_x", lay_x, 0);
        rst = 1'b0; fb_ready = 1'b1;
        late_done = 0;
        repeat (300) begin
            @(posedge clk);
            @(negedge clk);
            if (done !== 1'b0) late_done++;
        end
        checkOutput("rw_no_done", late_done, 0);
        applyStimulus(2'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        checkOutput("rw_resweep_writes", n_writes, CLEAR ? 256 : 12);
        checkOutput("rw_resweep_done", done_cyc, CLEAR ? 513 : 269);

        applyStimulus(2'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("t5_bg_cnt", bg_cnt, CLEAR ? 244 : 0);
        checkOutput("t5_w0_x", wx.size() > 0 ? wx[0] : 9'h1FF, CLEAR ? 0 : 7);
        checkOutput("t5_w0_y", wy.size() > 0 ? wy[0] : 9'h1FF, CLEAR ? 0 : 6);
        checkOutput("t5_w0_c", wc.size() > 0 ? wc[0] : 12'hBAD, CLEAR ? BG : C2);
        checkOutput("t5_done_cyc", done_cyc, CLEAR ? 513 : 269);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
